mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1023: BUSY cycles allowed without mem_op_finish before forced completion (10-bit counter).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_enable / d_enable  input  1  I-side / D-side request, held high until its finish is seen.
REQ-005 i_r_w / d_r_w  input  1  0 = read, 1 = write.
REQ-006 i_addr / d_addr  input  32  request address.
REQ-007 i_wr_data / d_wr_data  input  32  write data.
REQ-008 i_rd_data / d_rd_data  output  32  read data returned to the requester, registered.
REQ-009 i_finish / d_finish  output  1  one-cycle completion pulse to the requester.
REQ-010 mem_enable  output  1  memory request, registered.
REQ-011 mem_r_w  output  1  memory direction, registered.
REQ-012 mem_addr / mem_wr_data  output  32  memory address / write data, registered.
REQ-013 mem_rd_data  input  32  memory read data, valid with mem_op_finish.
REQ-014 mem_op_finish  input  1  memory completion strobe.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 err_timeout  output  1  sticky timeout flag.
REQ-017 err_clr  input  1  synchronous clear of err_timeout.

Function
REQ-018 FSM states SHALL be IDLE, BUSY, RESP and RELEASE.
REQ-019 IDLE: if any enable is sampled high, the arbiter SHALL latch the winner's r_w/addr/wr_data into the mem_* outputs, set mem_enable=1 and enter BUSY at the same edge (mem_enable visible the cycle after the request is sampled).
REQ-020 Arbitration SHALL be round-robin: on simultaneous requests, the requester not granted last wins; after reset, D wins the first tie.
REQ-021 BUSY: mem_* outputs SHALL hold stable; requester-side input changes SHALL be ignored.
REQ-022 BUSY with mem_op_finish=1: capture mem_rd_data into the granted *_rd_data (reads only; writes leave it unchanged), set mem_enable=0, set the granted *_finish=1, enter RESP.
REQ-023 RESP SHALL last exactly one cycle; *_finish SHALL be cleared on exit, giving a one-cycle pulse.
REQ-024 RELEASE: wait until the granted enable is low; then update last-grant and return to IDLE; a new request SHALL NOT be granted earlier than the cycle after RELEASE exits.
REQ-025 Timeout counter: cleared on BUSY entry, increments each BUSY cycle; when it equals TIMEOUT with no finish, behave as REQ-022 with rd_data forced to 0 and err_timeout set.
REQ-026 mem_op_finish outside BUSY SHALL be ignored.
REQ-027 The ungranted *_finish SHALL stay 0; at most one *_finish is high in any cycle.
REQ-028 err_clr SHALL clear err_timeout; a simultaneous timeout event wins (flag stays set).

Reset
REQ-029 rst_n low SHALL force IDLE at once, even mid-transaction.
REQ-030 rst_n low SHALL zero all outputs, the timeout counter and last-grant (= I, so D wins the first tie).

Structure
REQ-031 Package mem_arb_pkg SHALL hold the state encoding, the requester IDs (REQ_I=0, REQ_D=1) and the TIMEOUT default.
REQ-032 Round-robin selection SHALL be sub-module rr_arb2: combinational inputs req[1:0] and last; output grant.

Verification
REQ-033 Single I read at 0x0000_0040, memory finishes after 3 BUSY cycles with 0xDEADBEEF -> mem_addr=0x40, mem_r_w=0; i_rd_data=0xDEADBEEF with a one-cycle i_finish; d_finish stays 0.
REQ-034 I and D request in the same cycle after reset -> D served first, then I; after that, a second tie -> D served first again.
REQ-035 D write at 0x100 with data 0x12345678 -> mem_r_w=1, mem_wr_data=0x12345678; d_rd_data unchanged.
REQ-036 mem_op_finish never asserted, TIMEOUT=8 -> d_finish pulses after 8 BUSY cycles with d_rd_data=0 and err_timeout=1; err_clr then clears the flag.
REQ-037 rst_n dropped during BUSY -> mem_enable=0 and busy=0 immediately; a stray mem_op_finish after reset produces no *_finish.
REQ-038 Requester holds enable 3 cycles after its finish -> the arbiter stays in RELEASE, grants no one, then issues the pending other request.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port (instruction/data) memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RESP    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam int TIMEOUT_DEFAULT = 1023;
  localparam int TO_CNT_W        = 10;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: on a tie the requester not granted last wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  always_comb begin
    grant = REQ_I;
    if (&req)
      grant = ~last;
    else if (req[REQ_D])
      grant = REQ_D;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-side and D-side requests onto one memory port, with a
// completion timeout and a sticky timeout error flag.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic        i_r_w,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_data,
  output logic [31:0] i_rd_data,
  output logic        i_finish,
  input  logic        d_enable,
  input  logic        d_r_w,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wr_data,
  output logic [31:0] d_rd_data,
  output logic        d_finish,
  output logic        mem_enable,
  output logic        mem_r_w,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_op_finish,
  output logic        busy,
  output logic        err_timeout,
  input  logic        err_clr
);

  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

  arb_state_t          state;
  logic                gnt;
  logic                last_gnt;
  logic                arb_gnt;
  logic [TO_CNT_W-1:0] to_cnt;
  logic                timeout_hit;
  logic                gnt_enable;
  logic [31:0]         rd_sel;

  rr_arb2 u_rr_arb2 (
    .req   ({d_enable, i_enable}),
    .last  (last_gnt),
    .grant (arb_gnt)
  );

  // The current BUSY cycle is the TIMEOUT-th one and memory has not answered.
  assign timeout_hit = (state == ST_BUSY) && !mem_op_finish && (to_cnt == TO_LAST);
  assign gnt_enable  = (gnt == REQ_D) ? d_enable : i_enable;
  assign rd_sel      = mem_op_finish ? mem_rd_data : '0;
  assign busy        = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      gnt         <= REQ_I;
      last_gnt    <= REQ_I;
      to_cnt      <= '0;
      i_rd_data   <= '0;
      d_rd_data   <= '0;
      i_finish    <= 1'b0;
      d_finish    <= 1'b0;
      mem_enable  <= 1'b0;
      mem_r_w     <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (timeout_hit)
        err_timeout <= 1'b1;
      else if (err_clr)
        err_timeout <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (i_enable || d_enable) begin
            gnt         <= arb_gnt;
            mem_enable  <= 1'b1;
            mem_r_w     <= (arb_gnt == REQ_D) ? d_r_w     : i_r_w;
            mem_addr    <= (arb_gnt == REQ_D) ? d_addr    : i_addr;
            mem_wr_data <= (arb_gnt == REQ_D) ? d_wr_data : i_wr_data;
            to_cnt      <= '0;
            state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mem_op_finish || timeout_hit) begin
            if (!mem_r_w) begin
              if (gnt == REQ_D) d_rd_data <= rd_sel;
              else              i_rd_data <= rd_sel;
            end
            mem_enable <= 1'b0;
            d_finish   <= (gnt == REQ_D);
            i_finish   <= (gnt == REQ_I);
            state      <= ST_RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          i_finish <= 1'b0;
          d_finish <= 1'b0;
          state    <= ST_RELEASE;
        end
        ST_RELEASE: begin
          // Hold off re-arbitration until the served requester lets go.
          if (!gnt_enable) begin
            last_gnt <= gnt;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized rounds
// checked against a transaction-level model of arbitration order and read data.
module tb_mem_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_enable = 1'b0, i_r_w = 1'b0;
  logic [31:0] i_addr = '0, i_wr_data = '0;
  logic [31:0] i_rd_data;
  logic        i_finish;
  logic        d_enable = 1'b0, d_r_w = 1'b0;
  logic [31:0] d_addr = '0, d_wr_data = '0;
  logic [31:0] d_rd_data;
  logic        d_finish;
  logic        mem_enable, mem_r_w;
  logic [31:0] mem_addr, mem_wr_data;
  logic [31:0] mem_rd_data = '0;
  logic        mem_op_finish = 1'b0;
  logic        busy, err_timeout;
  logic        err_clr = 1'b0;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_enable      (i_enable),
    .i_r_w         (i_r_w),
    .i_addr        (i_addr),
    .i_wr_data     (i_wr_data),
    .i_rd_data     (i_rd_data),
    .i_finish      (i_finish),
    .d_enable      (d_enable),
    .d_r_w         (d_r_w),
    .d_addr        (d_addr),
    .d_wr_data     (d_wr_data),
    .d_rd_data     (d_rd_data),
    .d_finish      (d_finish),
    .mem_enable    (mem_enable),
    .mem_r_w       (mem_r_w),
    .mem_addr      (mem_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_rd_data   (mem_rd_data),
    .mem_op_finish (mem_op_finish),
    .busy          (busy),
    .err_timeout   (err_timeout),
    .err_clr       (err_clr)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] rd_exp [2];
  logic        last_exp;
  logic        err_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic side, input logic rw, input logic [31:0] addr,
                         input logic [31:0] wdata);
    if (side) begin
      d_enable = 1'b1; d_r_w = rw; d_addr = addr; d_wr_data = wdata;
    end else begin
      i_enable = 1'b1; i_r_w = rw; i_addr = addr; i_wr_data = wdata;
    end
  endtask

  // Serves one granted transaction; lat = BUSY cycle carrying mem_op_finish, 0 = never.
  task automatic serve(input logic side, input logic rw, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       input int lat, input int hold);
    int   n;
    bit   seen;
    logic ofin;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (mem_enable) seen = 1;
      else tick();
    end
    chk("grant_seen", 32'(seen), 1);
    chk("mem_addr", mem_addr, addr);
    chk("mem_r_w", 32'(mem_r_w), 32'(rw));
    if (rw) chk("mem_wr_data", mem_wr_data, wdata);
    n = 0;
    seen = 0;
    ofin = 1'b0;
    while (!seen && n < 20) begin
      n++;
      if (lat != 0 && n == lat) begin
        mem_op_finish = 1'b1;
        mem_rd_data = rdata;
      end else begin
        mem_rd_data = $urandom;
        if (side) d_addr = $urandom;
        else      i_addr = $urandom;
      end
      tick();
      mem_op_finish = 1'b0;
      ofin = ofin | (side ? i_finish : d_finish);
      if (side ? d_finish : i_finish) seen = 1;
      else if (mem_addr !== addr) chk("mem_addr_hold", mem_addr, addr);
    end
    chk("finish_seen", 32'(seen), 1);
    chk("other_finish", 32'(ofin), 0);
    chk("busy_cycles", n, (lat != 0) ? lat : TO);
    if (!rw) rd_exp[side] = (lat != 0) ? rdata : 32'h0;
    if (lat == 0) err_exp = 1'b1;
    chk("rd_data", side ? d_rd_data : i_rd_data, rd_exp[side]);
    chk("other_rd_data", side ? i_rd_data : d_rd_data, rd_exp[!side]);
    chk("mem_enable_off", 32'(mem_enable), 0);
    chk("err_timeout", 32'(err_timeout), 32'(err_exp));
    tick();
    chk("finish_pulse", 32'(side ? d_finish : i_finish), 0);
    for (int k = 0; k < hold; k++) begin
      chk("release_busy", 32'(busy), 1);
      chk("release_no_grant", 32'(mem_enable), 0);
      tick();
    end
    if (side) d_enable = 1'b0;
    else      i_enable = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 0);
    last_exp = side;
  endtask

  // One arbitration round: the requested sides raise enable together.
  task automatic round(input bit ie, input bit de, input logic irw, input logic drw,
                       input logic [31:0] ia, input logic [31:0] da,
                       input logic [31:0] iw, input logic [31:0] dw,
                       input logic [31:0] ir, input logic [31:0] dr,
                       input int li, input int ld, input int hi, input int hd);
    logic first;
    if (ie) set_req(1'b0, irw, ia, iw);
    if (de) set_req(1'b1, drw, da, dw);
    first = (ie && de) ? !last_exp : de;
    if (first) serve(1'b1, drw, da, dw, dr, ld, hd);
    else       serve(1'b0, irw, ia, iw, ir, li, hi);
    if (ie && de) begin
      if (first) serve(1'b0, irw, ia, iw, ir, li, hi);
      else       serve(1'b1, drw, da, dw, dr, ld, hd);
    end
  endtask

  initial begin
    rd_exp[0] = '0; rd_exp[1] = '0;
    last_exp = 1'b0;
    err_exp = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_enable", 32'(mem_enable), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_i_rd_data", i_rd_data, 0);
    chk("rst_err", 32'(err_timeout), 0);
    rst_n = 1'b1;
    tick();

    round(1, 0, 0, 0, 32'h40, 0, 0, 0, 32'hDEADBEEF, 0, 3, 1, 0, 0);
    round(1, 1, 0, 0, 32'h1000, 32'h2001, 0, 0, 32'hA5A5_0001, 32'h5A5A_0002, 2, 3, 1, 0);
    round(1, 1, 0, 0, 32'h1004, 32'h2005, 0, 0, 32'hA5A5_0003, 32'h5A5A_0004, 1, 2, 0, 2);
    round(0, 1, 0, 1, 0, 32'h100, 0, 32'h12345678, 0, 32'hFFFF_FFFF, 1, 2, 0, 0);
    round(0, 1, 0, 0, 0, 32'h180, 0, 0, 0, 32'h0BAD_0BAD, 1, 0, 0, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    err_exp = 1'b0;
    chk("err_clr", 32'(err_timeout), 0);

    set_req(1'b0, 1'b0, 32'h80, 0);
    tick(); tick();
    chk("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_enable", 32'(mem_enable), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_i_rd_data", i_rd_data, 0);
    i_enable = 1'b0;
    tick();
    rst_n = 1'b1;
    rd_exp[0] = '0; rd_exp[1] = '0;
    last_exp = 1'b0;
    mem_op_finish = 1'b1;
    mem_rd_data = 32'hFEED_F00D;
    tick();
    mem_op_finish = 1'b0;
    chk("stray_i_finish", 32'(i_finish), 0);
    chk("stray_d_finish", 32'(d_finish), 0);
    tick();
    chk("stray_busy", 32'(busy), 0);
    chk("stray_i_rd_data", i_rd_data, 0);

    set_req(1'b0, 1'b0, 32'h200, 0);
    tick();
    set_req(1'b1, 1'b0, 32'h300, 0);
    serve(1'b0, 1'b0, 32'h200, 0, 32'h1111_1111, 2, 3);
    serve(1'b1, 1'b0, 32'h300, 0, 32'h2222_2222, 4, 0);

    for (int r = 0; r < 40; r++) begin
      int mode;
      mode = $urandom_range(1, 3);
      round((mode & 1) != 0, (mode & 2) != 0, 1'($urandom), 1'($urandom),
            {$urandom, 1'b0} , {$urandom, 1'b1}, $urandom, $urandom, $urandom, $urandom,
            $urandom_range(1, 5), $urandom_range(1, 5),
            $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
